// File: rtl/dac_ramp_writer_if.sv
// Serial pin bundle between the ramp writer and the external DAC.
// The writer drives all three pins; the DAC side only observes them.
interface dac_ramp_writer_if;
  logic dac_sclk;
  logic dac_sync_n;
  logic dac_din;

  modport master (output dac_sclk, output dac_sync_n, output dac_din);
  modport slave  (input  dac_sclk, input  dac_sync_n, input  dac_din);
endinterface

// File: rtl/dac_ramp_writer.sv
// Steps a DAC code from start to stop, one {command, data} serial frame per
// ramp step, while dac_start is held high; all outputs are registered.
module dac_ramp_writer #(
  parameter int                DATA_W      = 16,
  parameter int                CMD_W       = 8,
  parameter logic [CMD_W-1:0]  CMD_CODE    = 8'h30,
  parameter int                SCLK_HALF   = 2,
  parameter int                HOLD_CYCLES = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dac_start,
  input  logic [DATA_W-1:0]  start_code,
  input  logic [DATA_W-1:0]  step_code,
  input  logic [DATA_W-1:0]  stop_code,
  dac_ramp_writer_if.master  dac,
  output logic               busy,
  output logic               frame_done,
  output logic               ramp_done
);

  localparam int FRAME_W    = CMD_W + DATA_W;
  localparam int SYNC_LOW   = 1 + FRAME_W * 2 * SCLK_HALF;
  localparam int GAP_RAW    = HOLD_CYCLES - SYNC_LOW;
  localparam int GAP_CYCLES = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int CNT_W      = $clog2(2 * SCLK_HALF + 1);
  localparam int BIT_W      = $clog2(FRAME_W + 1);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(SCLK_HALF);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(2 * SCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BITS_C     = BIT_W'(FRAME_W);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   code_q, code_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]   stop_q, stop_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic                sync_n_q, sync_n_d;
  logic                din_q, din_d;
  logic                busy_d, frame_done_d, ramp_done_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   next_code;
  logic                load_frame;
  logic [DATA_W-1:0]   load_code;

  // The reset branch clears every register, outputs included, so the pins
  // return to idle the instant reset asserts, even in the middle of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      step_q     <= '0;
      stop_q     <= '0;
      frame_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      sync_n_q   <= 1'b1;
      din_q      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ramp_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block, regardless of order.
      state_q    <= state_d;
      code_q     <= code_d;
      step_q     <= step_d;
      stop_q     <= stop_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      din_q      <= din_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      ramp_done  <= ramp_done_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch.
    state_d      = state_q;
    code_d       = code_q;
    step_d       = step_q;
    stop_d       = stop_q;
    frame_d      = frame_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    sync_n_d     = sync_n_q;
    din_d        = din_q;
    busy_d       = busy;
    frame_done_d = 1'b0;
    ramp_done_d  = ramp_done;
    load_frame   = 1'b0;
    load_code    = code_q;

    // Carry-out lands in the extra bit, so an overflowing step clamps to stop.
    sum       = {1'b0, code_q} + {1'b0, step_q};
    next_code = (sum > {1'b0, stop_q}) ? stop_q : sum[DATA_W-1:0];

    case (state_q)
      S_IDLE: begin
        sclk_d      = 1'b0;
        sync_n_d    = 1'b1;
        din_d       = 1'b0;
        busy_d      = 1'b0;
        ramp_done_d = 1'b0;
        if (dac_start) begin
          step_d     = step_code;
          stop_d     = stop_code;
          code_d     = start_code;
          busy_d     = 1'b1;
          load_frame = 1'b1;
          load_code  = start_code;
        end
      end

      // Frame select and first bit are already on the pins; raise sclk for bit 0.
      S_LOAD: begin
        sclk_d  = 1'b1;
        cnt_d   = CNT_W'(1);
        bit_d   = '0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == LAST_C) begin
          bit_d = bit_q + BIT_W'(1);
        end
        if (cnt_q == '0) begin
          if (bit_q == BITS_C) begin
            sync_n_d     = 1'b1;
            sclk_d       = 1'b0;
            din_d        = 1'b0;
            frame_done_d = 1'b1;
            cnt_d        = '0;
            gap_d        = '0;
            state_d      = S_GAP;
          end else begin
            sclk_d  = 1'b1;
            frame_d = frame_q << 1;
            din_d   = frame_q[FRAME_W-2];
          end
        end else if (cnt_q == HALF_C) begin
          sclk_d = 1'b0;
        end
      end

      S_GAP: begin
        if (gap_q != GAP_LAST_C) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (!dac_start) begin
          busy_d      = 1'b0;
          ramp_done_d = 1'b0;
          state_d     = S_IDLE;
        end else if ((code_q >= stop_q) || (step_q == '0)) begin
          busy_d      = 1'b0;
          ramp_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          code_d     = next_code;
          load_frame = 1'b1;
          load_code  = next_code;
        end
      end

      S_DONE: begin
        sclk_d      = 1'b0;
        sync_n_d    = 1'b1;
        din_d       = 1'b0;
        busy_d      = 1'b0;
        ramp_done_d = 1'b1;
        if (!dac_start) begin
          ramp_done_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        sclk_d      = 1'b0;
        sync_n_d    = 1'b1;
        din_d       = 1'b0;
        busy_d      = 1'b0;
        ramp_done_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Entering LOAD puts the frame select and MSB on the pins in the same edge.
    if (load_frame) begin
      frame_d  = {CMD_CODE, load_code};
      sync_n_d = 1'b0;
      sclk_d   = 1'b0;
      din_d    = frame_d[FRAME_W-1];
      state_d  = S_LOAD;
    end
  end

  assign dac.dac_sclk   = sclk_q;
  assign dac.dac_sync_n = sync_n_q;
  assign dac.dac_din    = din_q;

endmodule

// File: tb/tb_dac_ramp_writer.sv
// Directed bench for dac_ramp_writer: stimulus queues expected frames, a
// serial-pin monitor decodes each frame, checks its timing and pops/compares.
module tb_dac_ramp_writer;

  localparam int SCLK_HALF = 2;
  localparam int FRAME_W   = 24;
  localparam int SYNC_LOW  = 97;
  localparam int PERIOD    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dac_start = 1'b0;
  logic [15:0] start_code = '0;
  logic [15:0] step_code = '0;
  logic [15:0] stop_code = '0;
  logic        busy;
  logic        frame_done;
  logic        ramp_done;

  dac_ramp_writer_if dac ();

  dac_ramp_writer dut (
    .clk        (clk),
    .reset      (rst_n),
    .dac_start  (dac_start),
    .start_code (start_code),
    .step_code  (step_code),
    .stop_code  (stop_code),
    .dac        (dac),
    .busy       (busy),
    .frame_done (frame_done),
    .ramp_done  (ramp_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];

  // Monitor state
  int          frame_starts = 0;
  int          fd_count = 0;
  logic        m_prev_sync = 1'b1;
  logic        m_prev_sclk = 1'b0;
  logic        m_prev_din = 1'b0;
  logic        m_in_frame = 1'b0;
  logic        m_start_valid = 1'b0;
  int          m_sync_len = 0;
  int          m_hi_run = 0;
  int          m_lo_run = 0;
  int          m_nbits = 0;
  int          m_terr = 0;
  logic [23:0] m_bits = '0;
  longint      m_cyc = 0;
  longint      m_last_start = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Serial-pin monitor, sampled on the falling clk edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst_n) begin
        m_in_frame    = 1'b0;
        m_start_valid = 1'b0;
      end else begin
        if (frame_done) fd_count++;
        if (!busy) m_start_valid = 1'b0;
        if (m_in_frame && dac.dac_sync_n) begin
          check("sync_n low cycles", 64'(m_sync_len), 64'(SYNC_LOW));
          check("sclk bit count", 64'(m_nbits), 64'(FRAME_W));
          check("sclk/din timing errors", 64'(m_terr + ((m_lo_run != SCLK_HALF) ? 1 : 0)), 64'd0);
          check("frame_done at frame end", 64'(frame_done), 64'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected frame: got 0x%0h, none expected", m_bits);
          end else begin
            check("frame value", 64'(m_bits), 64'(exp_q.pop_front()));
          end
          m_in_frame = 1'b0;
        end else if (m_in_frame) begin
          m_sync_len++;
          if (dac.dac_sclk) begin
            if (!m_prev_sclk) begin
              if (m_lo_run != ((m_nbits == 0) ? 1 : SCLK_HALF)) m_terr++;
              m_hi_run = 1;
            end else begin
              m_hi_run++;
            end
          end else begin
            if (m_prev_sclk) begin
              if (m_hi_run != SCLK_HALF) m_terr++;
              if (dac.dac_din !== m_prev_din) m_terr++;
              m_bits = {m_bits[22:0], m_prev_din};
              m_nbits++;
              m_lo_run = 1;
            end else begin
              m_lo_run++;
            end
          end
        end else if (m_prev_sync && !dac.dac_sync_n) begin
          m_in_frame = 1'b1;
          m_sync_len = 1;
          m_nbits    = 0;
          m_terr     = (dac.dac_sclk !== 1'b0) ? 1 : 0;
          m_lo_run   = 1;
          m_hi_run   = 0;
          m_bits     = '0;
          frame_starts++;
          if (m_start_valid) check("frame start period", 64'(m_cyc - m_last_start), 64'(PERIOD));
          m_last_start  = m_cyc;
          m_start_valid = 1'b1;
        end
      end
      m_prev_sync = dac.dac_sync_n;
      m_prev_sclk = dac.dac_sclk;
      m_prev_din  = dac.dac_din;
    end
  end

  task automatic wait_ramp_done(input int budget);
    for (int i = 0; i < budget && !ramp_done; i++) @(negedge clk);
    check("ramp_done reached", 64'(ramp_done), 64'd1);
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("busy cleared", 64'(busy), 64'd0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && frame_starts < target; i++) @(negedge clk);
    check("frame start seen", 64'(frame_starts >= target), 64'd1);
  endtask

  // Expected frames must already be queued before calling.
  task automatic run_ramp(input logic [15:0] s, input logic [15:0] st, input logic [15:0] sp,
                          input int nframes);
    int fd0;
    fd0 = fd_count;
    @(negedge clk);
    start_code = s;
    step_code  = st;
    stop_code  = sp;
    dac_start  = 1'b1;
    @(negedge clk);
    check("busy after start", 64'(busy), 64'd1);
    start_code = 16'hABCD;
    step_code  = 16'h0001;
    stop_code  = 16'hFFFF;
    wait_ramp_done(nframes * PERIOD + 200);
    check("busy in DONE", 64'(busy), 64'd0);
    check("frames outstanding", 64'(exp_q.size()), 64'd0);
    check("frame_done pulses", 64'(fd_count - fd0), 64'(nframes));
    repeat (150) @(negedge clk);
    check("ramp_done held", 64'(ramp_done), 64'd1);
    dac_start = 1'b0;
    repeat (2) @(negedge clk);
    check("ramp_done cleared", 64'(ramp_done), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sync_n", 64'(dac.dac_sync_n), 64'd1);
    check("reset sclk", 64'(dac.dac_sclk), 64'd0);
    check("reset din", 64'(dac.dac_din), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset ramp_done", 64'(ramp_done), 64'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic ramp
    exp_q.push_back(24'h301000);
    exp_q.push_back(24'h302000);
    exp_q.push_back(24'h303000);
    exp_q.push_back(24'h304000);
    run_ramp(16'h1000, 16'h1000, 16'h4000, 4);

    // Clamp to stop
    exp_q.push_back(24'h300000);
    exp_q.push_back(24'h303000);
    exp_q.push_back(24'h306000);
    exp_q.push_back(24'h308000);
    run_ramp(16'h0000, 16'h3000, 16'h8000, 4);

    // Full-scale stop: the carry out of the last step clamps, never wraps
    exp_q.push_back(24'h30F000);
    exp_q.push_back(24'h30F800);
    exp_q.push_back(24'h30FFFF);
    run_ramp(16'hF000, 16'h0800, 16'hFFFF, 3);

    // start > stop, then step = 0
    exp_q.push_back(24'h305000);
    run_ramp(16'h5000, 16'h1000, 16'h2000, 1);
    exp_q.push_back(24'h302000);
    run_ramp(16'h2000, 16'h0000, 16'h4000, 1);

    // Abort 10 cycles into frame 2
    exp_q.push_back(24'h301000);
    exp_q.push_back(24'h302000);
    base = frame_starts;
    @(negedge clk);
    start_code = 16'h1000;
    step_code  = 16'h1000;
    stop_code  = 16'h4000;
    dac_start  = 1'b1;
    wait_frames(base + 2, 400);
    repeat (10) @(negedge clk);
    dac_start = 1'b0;
    wait_not_busy(300);
    check("abort ramp_done", 64'(ramp_done), 64'd0);
    check("abort frames outstanding", 64'(exp_q.size()), 64'd0);
    repeat (250) @(negedge clk);
    check("abort frame count", 64'(frame_starts - base), 64'd2);

    // Reset in the middle of a frame, then restart from start_code
    exp_q.push_back(24'h301000);
    base = frame_starts;
    @(negedge clk);
    dac_start = 1'b1;
    wait_frames(base + 1, 300);
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid-frame reset sync_n", 64'(dac.dac_sync_n), 64'd1);
    check("mid-frame reset sclk", 64'(dac.dac_sclk), 64'd0);
    check("mid-frame reset busy", 64'(busy), 64'd0);
    check("mid-frame reset din", 64'(dac.dac_din), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    exp_q.push_back(24'h301000);
    exp_q.push_back(24'h302000);
    exp_q.push_back(24'h303000);
    exp_q.push_back(24'h304000);
    #1 rst_n = 1'b1;
    wait_ramp_done(4 * PERIOD + 200);
    check("restart frames outstanding", 64'(exp_q.size()), 64'd0);
    dac_start = 1'b0;
    repeat (5) @(negedge clk);
    check("final ramp_done", 64'(ramp_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_ramp_writer.md
Name: dac_ramp_writer

Overview:
- Downstream consumer of the DAC start/enable level (`dac_start`) produced in the DAC clock domain.
- While `dac_start` is high, it steps a DAC code from `start_code` to `stop_code` in increments of `step_code`, one code per frame.
- Each code is serialized as a {command, data} SPI-style frame to the external DAC.
- Drives the DAC serial pins directly and reports per-frame and end-of-ramp status to the control logic.

Parameters:
- `DATA_W`, 16: DAC code width.
- `CMD_W`, 8: command field width; frame width `FRAME_W` = `CMD_W` + `DATA_W` (24).
- `CMD_CODE`, 8'h30: command field sent in every frame (write and update).
- `SCLK_HALF`, 2: clk cycles per `dac_sclk` half-period; must be ≥ 1.
- `HOLD_CYCLES`, 100: clk cycles from one frame start to the next frame start (ramp step period).

Ports:
- `clk`  in  1  DAC clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `dac_start`  in  1  run enable, synchronous to `clk`; level, not pulse.
- `start_code`  in  `DATA_W`  first code of the ramp; sampled on run start.
- `step_code`  in  `DATA_W`  unsigned increment; sampled on run start.
- `stop_code`  in  `DATA_W`  final code, inclusive; sampled on run start.
- `dac_sclk`  out  1  serial clock; idle low.
- `dac_sync_n`  out  1  frame select, active low; idle high.
- `dac_din`  out  1  serial data, MSB first.
- `busy`  out  1  high from run start until the FSM returns to IDLE or DONE.
- `frame_done`  out  1  one-cycle pulse after each completed frame.
- `ramp_done`  out  1  high in DONE: ramp reached `stop_code`.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert not required internally) forces the following at once, mid-frame included:
  - `dac_sync_n`=1, `dac_sclk`=0, `dac_din`=0
  - `busy`=0, `frame_done`=0, `ramp_done`=0
  - state=IDLE, code register=0
- IDLE:
  - Outputs hold idle values.
  - On `dac_start`=1: latch `start_code`/`step_code`/`stop_code` into internal registers, set code=`start_code`, `busy`=1, go to LOAD.
  - Later changes on the code inputs are ignored until the next run.
- LOAD (1 cycle):
  - Frame register = {`CMD_CODE`, code}.
  - `dac_sync_n`=0, `dac_sclk`=0, `dac_din`=frame MSB.
  - Go to SHIFT.
- SHIFT:
  - `FRAME_W` bit periods. Each bit period is `SCLK_HALF` cycles with `dac_sclk` high, then `SCLK_HALF` cycles with `dac_sclk` low.
  - `dac_din` updates only at the start of each high phase, to the next bit; the first bit was presented in LOAD. The DAC samples on the falling edge.
  - After the last low phase: `dac_sync_n`=1, `dac_sclk`=0, `frame_done` pulses 1 cycle, go to GAP.
  - `dac_sync_n` is low for exactly 1 + `FRAME_W`·2·`SCLK_HALF` cycles (97 with defaults). A frame is never truncated except by reset.
- GAP:
  - Lasts max(1, `HOLD_CYCLES` − (1 + `FRAME_W`·2·`SCLK_HALF`)) cycles. Defaults: 3 cycles, giving 100 cycles between frame starts.
  - At the end of GAP, checks apply in this priority:
    - (a) `dac_start`=0 → IDLE, `busy`=0, `ramp_done`=0 (abort).
    - (b) code == stop, or step == 0, or code > stop → DONE.
    - (c) next = code + step, computed in `DATA_W`+1 bits. If next > stop (this includes carry-out), code=stop; else code=next. Go to LOAD.
- DONE:
  - `busy`=0, `ramp_done`=1, serial pins idle.
  - Stays until `dac_start`=0, then IDLE with `ramp_done`=0.
  - A new ramp requires `dac_start` to go low, then high again.
- Boundary cases:
  - `start_code` > `stop_code`: exactly one frame with `start_code`, then DONE.
  - `step_code`=0: exactly one frame, then DONE.
  - `stop_code`=0xFFFF with any step: the last frame is 0xFFFF; the code never wraps.
  - `dac_start` dropping during LOAD/SHIFT: the frame completes, then the abort is taken at the end of GAP.
- Undefined state encoding → IDLE with idle outputs.

Test Plan:
- Basic ramp: start=0x1000, step=0x1000, stop=0x4000, `dac_start` held high → frames 0x301000, 0x302000, 0x303000, 0x304000; 4 `frame_done` pulses; frame starts 100 cycles apart; `ramp_done`=1.
- Clamp: start=0x0000, step=0x3000, stop=0x8000 → codes 0x0000, 0x3000, 0x6000, 0x8000; no code exceeds 0x8000.
- Timing: defaults → each `dac_sync_n` low pulse is exactly 97 cycles. Each of 24 `dac_sclk` periods is 2 cycles high and 2 low, and `dac_din` is stable across every falling edge.
- Abort: drop `dac_start` 10 cycles into frame 2 → frame 2 completes intact, no frame 3, `busy`=0 and `ramp_done`=0 after GAP.
- Reset mid-frame: assert `reset`=0 during SHIFT → same cycle: `dac_sync_n`=1, `dac_sclk`=0, `busy`=0. After release with `dac_start`=1, the ramp restarts from `start_code`.
- Degenerate: start=0x5000 > stop=0x2000 → single frame 0x305000, then DONE. Repeat with step=0 → single frame.
